// File: rtl/spi_frame_receiver.sv
// SPI frame receiver (slave, receive only).
// Samples an asynchronous SPI bus on the system clock, assembles NUM_BYTES
// bytes per chip-enable window and publishes a whole frame at once on data_o.
// Short frames (CE dropped before the last byte) raise frame_error_o and
// leave data_o untouched.
module spi_frame_receiver #(
   parameter int NUM_BYTES   = 10,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   sys_clk_i,
   input  logic                   rst_ni,
   input  logic                   sclk_i,
   input  logic                   mosi_i,
   input  logic                   chip_enable_i,
   output logic [8*NUM_BYTES-1:0] data_o,
   output logic                   frame_valid_o,
   output logic                   frame_error_o,
   output logic                   busy_o,
   output logic [4:0]             byte_count_o
);

   localparam logic       SCLK_IDLE   = (CPOL != 0);
   localparam bit         SAMPLE_RISE = (CPOL == CPHA);
   localparam logic [4:0] LAST_BYTE   = 5'(NUM_BYTES - 1);
   localparam logic [4:0] FULL_COUNT  = 5'(NUM_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] ce_sync_q;
   logic [SYNC_STAGES-1:0] prime_q;
   logic                   sclk_d_q;
   logic                   ce_d_q;
   logic                   armed_q;

   logic sclk_s, mosi_s, ce_s;
   logic sample_edge, ce_rise, ce_fall;

   logic [2:0]             bit_cnt_q;
   logic [4:0]             byte_cnt_q;
   logic [7:0]             shift_q;
   logic [8*NUM_BYTES-1:0] shadow_q;
   logic [8*NUM_BYTES-1:0] frame_next;
   logic [7:0]             byte_next;
   logic                   byte_done;

   logic start, shift_en, frame_done, frame_err;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign ce_s   = ce_sync_q[SYNC_STAGES-1];

   // All three bus lines share the same synchronizer depth so mosi stays aligned with sclk.
   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
         mosi_sync_q <= '0;
         ce_sync_q   <= '0;
         sclk_d_q    <= SCLK_IDLE;
         ce_d_q      <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], chip_enable_i};
         sclk_d_q    <= sclk_s;
         ce_d_q      <= ce_s;
      end
   end

   // After reset, CE must be seen low (once the synchronizer holds real data)
   // before a rising edge counts, so a frame already in flight is ignored.
   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prime_q <= '0;
         armed_q <= 1'b0;
      end else begin
         prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
         armed_q <= armed_q | (prime_q[SYNC_STAGES-1] & ~ce_s);
      end
   end

   assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_d_q) : (~sclk_s & sclk_d_q);
   assign ce_rise     = armed_q & ce_s & ~ce_d_q;
   assign ce_fall     = ~ce_s & ce_d_q;

   assign byte_next = (MSB_FIRST != 0) ? {shift_q[6:0], mosi_s} : {mosi_s, shift_q[7:1]};
   assign byte_done = (bit_cnt_q == 3'd7);

   // Shadow buffer with the byte being completed merged in at its slot.
   always_comb begin
      frame_next = shadow_q;
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (byte_cnt_q == 5'(k)) begin
            frame_next[8*k +: 8] = byte_next;
         end
      end
   end

   // State register.
   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath strobes; a final edge beats a simultaneous CE fall.
   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      frame_err  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ce_rise) begin
               state_d = RECV;
               start   = 1'b1;
            end
         end
         RECV: begin
            if (sample_edge) begin
               shift_en = 1'b1;
               if (byte_done && (byte_cnt_q == LAST_BYTE)) begin
                  frame_done = 1'b1;
                  state_d    = DONE;
               end
            end
            if (ce_fall && !frame_done) begin
               frame_err = 1'b1;
               shift_en  = 1'b0;
               state_d   = IDLE;
            end
         end
         DONE: begin
            if (ce_rise) begin
               state_d = RECV;
               start   = 1'b1;
            end else if (ce_fall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bit/byte assembly; data_o only ever takes a complete frame.
   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         shadow_q   <= '0;
         data_o     <= '0;
      end else begin
         if (start) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
         end else if (shift_en) begin
            shift_q   <= byte_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) begin
               shadow_q <= frame_next;
               if (byte_cnt_q != FULL_COUNT) begin
                  byte_cnt_q <= byte_cnt_q + 5'd1;
               end
            end
         end
         if (frame_done) begin
            data_o <= frame_next;
         end
      end
   end

   // Status pulses, one cycle after the edge that caused them.
   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_valid_o <= 1'b0;
         frame_error_o <= 1'b0;
      end else begin
         frame_valid_o <= frame_done;
         frame_error_o <= frame_err;
      end
   end

   assign busy_o       = (state_q == RECV);
   assign byte_count_o = byte_cnt_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: two instances share one SPI bus, one with the
// default mode and one with CPOL=1/CPHA=1, LSB first, 2-byte frames.
module tb_spi_frame_receiver;

   localparam int NB_A = 10;
   localparam int NB_B = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ce, mosi, sclk_a, sclk_b;
   logic [79:0] data_a;
   logic [15:0] data_b;
   logic        fv_a, fe_a, busy_a, fv_b, fe_b, busy_b;
   logic [4:0]  bc_a, bc_b;

   spi_frame_receiver #(.NUM_BYTES(NB_A)) u_dut_a (
      .sys_clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk_a), .mosi_i(mosi),
      .chip_enable_i(ce), .data_o(data_a), .frame_valid_o(fv_a),
      .frame_error_o(fe_a), .busy_o(busy_a), .byte_count_o(bc_a)
   );

   spi_frame_receiver #(.NUM_BYTES(NB_B), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut_b (
      .sys_clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk_b), .mosi_i(mosi),
      .chip_enable_i(ce), .data_o(data_b), .frame_valid_o(fv_b),
      .frame_error_o(fe_b), .busy_o(busy_b), .byte_count_o(bc_b)
   );

   typedef struct {
      bit          is_err;
      logic [79:0] data;
   } ev_t;

   int          tests = 0;
   int          fails = 0;
   ev_t         qa[$];
   ev_t         qb[$];
   logic [79:0] cur_a = '0;
   logic [79:0] cur_b = '0;
   int          vcnt[2];
   int          ecnt[2];
   bit          bq[$];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected frame for a receiver of nb bytes from the first 8*nb bits on the wire.
   function automatic logic [79:0] model_frame(input int nb, input bit msbf);
      logic [79:0] r;
      r = '0;
      for (int k = 0; k < nb; k++)
         for (int i = 0; i < 8; i++)
            if (bq[8*k+i]) r[8*k + (msbf ? 7-i : i)] = 1'b1;
      return r;
   endfunction

   task automatic push_byte(input logic [7:0] b, input bit msbf);
      for (int i = 0; i < 8; i++) bq.push_back(msbf ? b[7-i] : b[i]);
   endtask

   task automatic cmp_dut(input int d, input logic fv, input logic fe, input logic [79:0] dat);
      ev_t e;
      bit  have;
      check($sformatf("d%0d_valid_error_exclusive", d), {79'd0, fv & fe}, 80'd0);
      if (fv || fe) begin
         have = (d == 0) ? (qa.size() > 0) : (qb.size() > 0);
         tests++;
         if (!have) begin
            fails++;
            $display("FAIL d%0d_unexpected_pulse: valid=%b error=%b, no pulse expected", d, fv, fe);
         end else begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            check($sformatf("d%0d_pulse_is_error", d), {79'd0, fe}, {79'd0, e.is_err});
            if (fv && !e.is_err) begin
               check($sformatf("d%0d_frame_data", d), dat, e.data);
               if (d == 0) cur_a = e.data;
               else        cur_b = e.data;
            end
            if (fv) vcnt[d]++;
            if (fe) ecnt[d]++;
         end
      end else begin
         check($sformatf("d%0d_data_hold", d), dat, (d == 0) ? cur_a : cur_b);
      end
   endtask

   // Single compare process against the frame-level model.
   always @(negedge clk) begin
      if (!rst_n) begin
         cur_a = '0;
         cur_b = '0;
      end else begin
         cmp_dut(0, fv_a, fe_a, data_a);
         cmp_dut(1, fv_b, fe_b, {64'd0, data_b});
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_data_a"}, data_a, 80'd0);
      check({tag, "_valid_a"}, {79'd0, fv_a}, 80'd0);
      check({tag, "_error_a"}, {79'd0, fe_a}, 80'd0);
      check({tag, "_busy_a"}, {79'd0, busy_a}, 80'd0);
      check({tag, "_count_a"}, {75'd0, bc_a}, 80'd0);
      check({tag, "_data_b"}, {64'd0, data_b}, 80'd0);
      check({tag, "_valid_b"}, {79'd0, fv_b}, 80'd0);
      check({tag, "_error_b"}, {79'd0, fe_b}, 80'd0);
      check({tag, "_busy_b"}, {79'd0, busy_b}, 80'd0);
      check({tag, "_count_b"}, {75'd0, bc_b}, 80'd0);
   endtask

   // Sends the first nbits of bq in one CE window; h is the SCLK half period.
   task automatic send_frame(input int nbits, input int h, input bit coincident, input int rst_bit);
      ev_t e;
      bit  killed;
      int  exp_a, exp_b;
      killed = 1'b0;
      repeat (4) @(negedge clk);
      e.is_err = (nbits < 8*NB_A);
      e.data   = e.is_err ? 80'd0 : model_frame(NB_A, 1'b1);
      qa.push_back(e);
      e.is_err = (nbits < 8*NB_B);
      e.data   = e.is_err ? 80'd0 : model_frame(NB_B, 1'b0);
      qb.push_back(e);
      ce = 1'b1;
      repeat (6) @(negedge clk);
      check("start_busy_a", {79'd0, busy_a}, 80'd1);
      check("start_busy_b", {79'd0, busy_b}, 80'd1);
      check("start_count_a", {75'd0, bc_a}, 80'd0);
      check("start_count_b", {75'd0, bc_b}, 80'd0);
      for (int i = 0; i < nbits; i++) begin
         sclk_a = 1'b0;
         sclk_b = 1'b0;
         mosi   = bq[i];
         if (i == rst_bit) begin
            #2 rst_n = 1'b0;
            #1 check_all_zero("reset_mid_frame");
            qa.delete();
            qb.delete();
            killed = 1'b1;
            #(h-3) rst_n = 1'b1;
         end else begin
            #(h);
         end
         if (coincident && i == nbits-1) ce = 1'b0;
         sclk_a = 1'b1;
         sclk_b = 1'b1;
         #(h);
      end
      sclk_a = 1'b0;
      if (!coincident) begin
         repeat (6) @(negedge clk);
         exp_a = killed ? 0 : ((nbits/8 < NB_A) ? nbits/8 : NB_A);
         exp_b = killed ? 0 : ((nbits/8 < NB_B) ? nbits/8 : NB_B);
         check("end_count_a", {75'd0, bc_a}, 80'(exp_a));
         check("end_count_b", {75'd0, bc_b}, 80'(exp_b));
         check("end_busy_a", {79'd0, busy_a}, {79'd0, !killed && nbits < 8*NB_A});
         check("end_busy_b", {79'd0, busy_b}, {79'd0, !killed && nbits < 8*NB_B});
         ce = 1'b0;
      end
      repeat (10) @(negedge clk);
      check("idle_busy_a", {79'd0, busy_a}, 80'd0);
      check("idle_busy_b", {79'd0, busy_b}, 80'd0);
      check("pending_events_a", 80'(qa.size()), 80'd0);
      check("pending_events_b", 80'(qb.size()), 80'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, e0, nb, h;
      bit co;
      rst_n = 1'b0; ce = 1'b0; mosi = 1'b0; sclk_a = 1'b0; sclk_b = 1'b1;
      vcnt[0] = 0; vcnt[1] = 0; ecnt[0] = 0; ecnt[1] = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Frame 0x01..0x0A, MSB first.
      bq.delete();
      for (int k = 1; k <= 10; k++) push_byte(8'(k), 1'b1);
      v0 = vcnt[0];
      send_frame(80, 20, 1'b0, -1);
      check("frame1_valid_count", 80'(vcnt[0] - v0), 80'd1);
      check("frame1_byte0", {72'd0, data_a[7:0]}, 80'h01);
      check("frame1_byte9", {72'd0, data_a[79:72]}, 80'h0A);

      // Short frame of three 0xFF bytes.
      bq.delete();
      for (int k = 0; k < 3; k++) push_byte(8'hFF, 1'b1);
      e0 = ecnt[0];
      send_frame(24, 20, 1'b0, -1);
      check("short_error_count", 80'(ecnt[0] - e0), 80'd1);
      check("short_keeps_byte0", {72'd0, data_a[7:0]}, 80'h01);
      check("short_keeps_byte9", {72'd0, data_a[79:72]}, 80'h0A);

      // 0xA5, 0x3C LSB first for the mode-3 receiver.
      bq.delete();
      push_byte(8'hA5, 1'b0);
      push_byte(8'h3C, 1'b0);
      send_frame(16, 30, 1'b0, -1);
      check("mode3_frame", {64'd0, data_b}, 80'h3CA5);

      // Twelve bytes into a ten-byte frame.
      bq.delete();
      for (int k = 0; k < 12; k++) push_byte(8'($urandom), 1'b1);
      v0 = vcnt[0];
      send_frame(96, 20, 1'b0, -1);
      check("overlong_valid_count", 80'(vcnt[0] - v0), 80'd1);

      // Reset in the middle of byte 4, then a clean frame.
      bq.delete();
      for (int k = 0; k < 10; k++) push_byte(8'($urandom), 1'b1);
      send_frame(80, 20, 1'b0, 28);
      bq.delete();
      for (int k = 0; k < 10; k++) push_byte(8'($urandom), 1'b1);
      v0 = vcnt[0];
      send_frame(80, 30, 1'b0, -1);
      check("after_reset_valid_count", 80'(vcnt[0] - v0), 80'd1);

      // Last sample edge together with the CE fall.
      bq.delete();
      for (int k = 0; k < 10; k++) push_byte(8'($urandom), 1'b1);
      v0 = vcnt[0];
      e0 = ecnt[0];
      send_frame(80, 20, 1'b1, -1);
      check("coincident_valid_count", 80'(vcnt[0] - v0), 80'd1);
      check("coincident_error_count", 80'(ecnt[0] - e0), 80'd0);

      // CE pulse with no bits at all.
      e0 = ecnt[0];
      send_frame(0, 20, 1'b0, -1);
      check("empty_error_count", 80'(ecnt[0] - e0), 80'd1);

      // Random frames of random length and SCLK rate.
      for (int t = 0; t < 8; t++) begin
         case ($urandom_range(0, 2))
            0:       nb = $urandom_range(1, 79);
            1:       nb = 80;
            default: nb = $urandom_range(81, 120);
         endcase
         h  = 10 * $urandom_range(2, 4);
         co = ($urandom_range(0, 1) == 1);
         bq.delete();
         for (int i = 0; i < nb; i++) bq.push_back(1'($urandom));
         send_frame(nb, h, co, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_frame_receiver.md
SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 10, the number of bytes per frame (legal 1..16).
REQ-002 SHALL have parameter CPOL, default 0, the SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 0, the sampling phase; the sample edge is rising when CPOL==CPHA and falling otherwise.
REQ-004 SHALL have parameter MSB_FIRST, default 1, the bit order within a byte (1 = MSB first, 0 = LSB first).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth (legal 2..3).
REQ-006 SHALL have port sys_clk_i, input, 1 bit, the single system clock.
REQ-007 SHALL have port rst_ni, input, 1 bit, an asynchronous active-low reset.
REQ-008 SHALL have port sclk_i, input, 1 bit, the asynchronous SPI clock.
REQ-009 SHALL have port mosi_i, input, 1 bit, the asynchronous SPI data.
REQ-010 SHALL have port chip_enable_i, input, 1 bit, the asynchronous chip select (active high).
REQ-011 SHALL have port data_o, output, 8*NUM_BYTES bits, the last complete frame; byte k (k=0 first received) sits on [8k+7:8k].
REQ-012 SHALL have port frame_valid_o, output, 1 bit, a one-cycle pulse when data_o updates.
REQ-013 SHALL have port frame_error_o, output, 1 bit, a one-cycle pulse on a short frame.
REQ-014 SHALL have port busy_o, output, 1 bit, high while in state RECV.
REQ-015 SHALL have port byte_count_o, output, 5 bits, the bytes completed in the current frame.

Function
REQ-016 SHALL synchronize sclk_i, mosi_i and chip_enable_i through SYNC_STAGES flops each, with identical depth so data stays aligned to the clock edge.
REQ-017 SHALL detect sample edges and chip-enable edges from the last synchronizer stage plus one delay flop.
REQ-018 SHALL implement states IDLE, RECV and DONE.
REQ-019 SHALL move IDLE->RECV on a CE rising edge, clearing the bit counter, byte counter and shift register; data_o is not cleared.
REQ-020 SHALL, in RECV, shift in one synchronized mosi bit per sample edge while CE is high (left shift if MSB_FIRST, right shift otherwise).
REQ-021 SHALL, on the 8th bit, write the assembled byte (including the current bit) into a shadow buffer at the byte-count index, then increment byte_count_o.
REQ-022 SHALL, when byte NUM_BYTES-1 completes, copy the shadow buffer to data_o on the same edge, pulse frame_valid_o in the next cycle, and enter DONE.
REQ-023 SHALL hold data_o stable from one frame_valid_o to the next, with partial frames never visible on it.
REQ-024 SHALL, in DONE, ignore further sample edges and return to IDLE on a CE falling edge.
REQ-025 SHALL, on a CE fall in RECV, pulse frame_error_o for one cycle, leave data_o unchanged and return to IDLE; the error applies even with zero bits received.
REQ-026 SHALL, when the final sample edge and the CE fall arrive in the same cycle, complete the frame first with no error.
REQ-027 SHALL, when a CE rise occurs in DONE without an intervening fall (a glitch), restart RECV.
REQ-028 SHALL never assert frame_valid_o and frame_error_o in the same cycle.
REQ-029 SHALL saturate byte_count_o at NUM_BYTES.
REQ-030 SHALL operate correctly when sys_clk_i is at least 4x the SCLK frequency.

Reset
REQ-031 SHALL, when rst_ni is low, immediately force state IDLE, data_o=0, frame_valid_o=0, frame_error_o=0, busy_o=0, byte_count_o=0, all counters, shadow buffer and shift register to 0, and synchronizers to the CPOL level for sclk and 0 for the others.
REQ-032 SHALL, after rst_ni deasserts mid-frame, ignore the remaining bits until a new CE rising edge.

Verification
REQ-033 Default parameters: send a 10-byte frame 0x01..0x0A -> exactly one frame_valid_o pulse; data_o[7:0]=0x01 and data_o[79:72]=0x0A.
REQ-034 CE drops after 3 bytes (0xFF,0xFF,0xFF) following a prior good frame -> one frame_error_o pulse; data_o retains the prior frame; state IDLE.
REQ-035 CPOL=1, CPHA=1, MSB_FIRST=0, NUM_BYTES=2: send 0xA5,0x3C -> data_o=16'h3CA5.
REQ-036 12 bytes sent with NUM_BYTES=10 -> valid pulses once; bytes 11-12 ignored; byte_count_o=10 until CE falls.
REQ-037 rst_ni pulsed low mid-byte 4 -> outputs are 0 at once; the next full frame is received correctly.
REQ-038 Final sample edge coincident with the CE fall (sys_clk=4x sclk) -> frame_valid_o=1, frame_error_o stays 0.
